serial_cla_adder: RTL and testbench
===================================

SERIAL_CLA_ADDER -- requirements
Module: serial_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in; ignored when sub=1.
REQ-009 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-010 out_valid  output  1  result held valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of the MSB nibble.
REQ-014 ovf  output  1  two's-complement overflow.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 On in_valid&&in_ready: capture a, b (inverted if sub=1), carry = sub ? 1 : cin; clear nibble index; go to CALC.
REQ-018 CALC: each cycle, add nibble[idx] of captured A and B plus the carry register through one 4-bit carry-lookahead slice.
REQ-019 CALC: write the slice sum into sum[4*idx+3:4*idx], load the slice carry-out into the carry register, increment idx.
REQ-020 Nibble processing SHALL be LSB-first, with exactly WIDTH/4 CALC cycles.
REQ-021 After the final nibble (idx = WIDTH/4-1), go to DONE; cout = final slice carry-out.
REQ-022 ovf = (A_msb == Beff_msb) && (sum_msb != A_msb), registered with cout.
REQ-023 Latency: handshake accepted at edge t gives out_valid=1 from edge t+WIDTH/4.
REQ-024 DONE: sum, cout and ovf SHALL hold stable until out_valid&&out_ready; that edge returns to IDLE.
REQ-025 Back-to-back throughput SHALL be one result per WIDTH/4+2 cycles with out_ready tied high.
REQ-026 in_valid in CALC/DONE SHALL be ignored; operand input changes after capture SHALL NOT affect the result.
REQ-027 The nibble index SHALL be wide enough for WIDTH/4-1 and SHALL NOT wrap inside a transaction.

Reset
REQ-028 With rst=1 at a clock edge: state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 after that edge.
REQ-029 Reset in CALC or DONE SHALL abort the transaction with no result emitted; rst SHALL take priority over handshakes in the same cycle.

Structure
REQ-030 Package serial_cla_pkg SHALL hold the state enum type (IDLE, CALC, DONE) and the constant NIBBLE_W = 4.
REQ-031 Sub-module cla4_slice SHALL be the only sub-module: a purely combinational 4-bit generate/propagate lookahead adder with inputs x[3:0], y[3:0], ci and outputs s[3:0], co, instantiated once.

Verification
REQ-032 WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0, out_valid 4 cycles after accept.
REQ-033 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all nibbles).
REQ-034 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1; a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0; in_valid pulses with other operands are ignored.
REQ-036 Assert rst during the 2nd CALC cycle -> next cycle IDLE, out_valid=0, sum=0; a new transaction 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/serial_cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
// The FSM state type and the slice width live here so the top and the bench agree.
package serial_cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit generate/propagate carry-lookahead adder slice.
// All internal carries are flattened into two-level logic from g, p and ci.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Each carry is expanded directly rather than rippled from the previous one
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/serial_cla_adder.sv
// Nibble-serial adder/subtractor: one 4-bit lookahead slice reused LSB-first over
// WIDTH/4 cycles, with a valid/ready handshake on both the operand and result sides.
module serial_cla_adder
  import serial_cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("serial_cla_adder: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [NIBBLE_W-1:0] slice_x;
  logic [NIBBLE_W-1:0] slice_y;
  logic [NIBBLE_W-1:0] slice_s;
  logic               slice_co;

  assign slice_x = a_reg[idx*NIBBLE_W +: NIBBLE_W];
  assign slice_y = b_reg[idx*NIBBLE_W +: NIBBLE_W];

  cla4_slice u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // b is stored already inverted for subtraction, so the slice only ever adds
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry <= slice_co;
          if (idx == LAST_IDX) begin
            cout  <= slice_co;
            ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (slice_s[NIBBLE_W-1] != a_reg[WIDTH-1]);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cla_adder.sv
// Directed self-checking bench for serial_cla_adder at WIDTH=16 with hand-computed
// results covering add, subtract, carry/overflow corners, result hold and mid-flight reset.
module tb_serial_cla_adder;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks;
  int errors;

  serial_cla_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair, scrambles the inputs after capture, then checks the
  // latency and the held result; out_ready decides whether DONE is left afterwards
  task automatic applyStimulus(input string tag, input logic [15:0] va, input logic [15:0] vb,
                               input logic vcin, input logic vsub, input logic [15:0] esum,
                               input logic ecout, input logic eovf);
    int lat;
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hA5A5; b = 16'h5A5A; cin = ~vcin; sub = ~vsub;
    checkOutput({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, 32'd4);
    checkOutput({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
    checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    if (out_ready) begin
      tick();
      checkOutput({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sum", {16'd0, sum}, 32'd0);
    checkOutput("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);

    applyStimulus("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    applyStimulus("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    applyStimulus("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    applyStimulus("add_cin", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    applyStimulus("sub_cin_ign", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Result must hold through a stalled consumer while new offers are ignored
    out_ready = 1'b0;
    applyStimulus("hold", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
      tick();
      checkOutput("hold_sum", {16'd0, sum}, 32'h3333);
      checkOutput("hold_flags", {29'd0, out_valid, cout, ovf}, 32'h4);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("hold_release", {30'd0, in_ready, out_valid}, 32'h2);

    // Reset lands during the second CALC cycle and must abort the transaction
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_sum", {16'd0, sum}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("abort_no_result", {30'd0, out_valid, in_ready}, 32'h1);
    applyStimulus("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
